fp_round_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 rounding stage for the FaceVerify floating-point datapath. It takes an unrounded result with guard, round and sticky bits from the adder, multiplier or MAC front-ends. It returns the rounded value two cycles later with exception flags. It supports any exponent/mantissa split, five rounding modes selected per transaction, valid/ready backpressure, and a sideband tag carried alongside each result.

---
 rtl/fp_round_pipe.sv | 172 +++++++++++++++++
 tb/tb_fp_round_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: two-stage IEEE-754 rounding pipeline.
//
// S1 decodes the unrounded operand and registers the increment decision for the selected
// rounding mode. S2 applies the increment, handles mantissa carry-out into the exponent
// (including overflow to infinity) and registers the result with its tag and flags.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = global advance enable)
//   in_data             {sign, exponent, mantissa}, unrounded
//   in_grs              {guard, round, sticky}
//   in_mode             000 RNE, 001 RTZ, 010 RUP, 011 RDN, 100 RMM, others RNE
//   in_tag              opaque sideband carried with the result
//   out_valid/out_ready output handshake
//   out_data            rounded result
//   out_tag             tag of this result
//   out_flags           {overflow, underflow, inexact}
//
// Build option: define FP_ROUND_FLAGS_EN to compute out_flags. When undefined, the flag
// logic is absent and out_flags is tied to 000.
module fp_round_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned D_LEN = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_LEN-1:0] in_data,
  input  logic [2:0]       in_grs,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_LEN-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags
);

  localparam logic [EXP_W-1:0] ExpMax   = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] ExpMaxM1 = {{(EXP_W-1){1'b1}}, 1'b0};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Input decode and increment decision
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic             in_inexact;
  logic             in_inc;

  assign in_sign    = in_data[D_LEN-1];
  assign in_exp     = in_data[MAN_W +: EXP_W];
  assign in_man     = in_data[MAN_W-1:0];
  assign in_inexact = |in_grs;

  always_comb begin
    in_inc = 1'b0;
    case (in_mode)
      3'b001:  in_inc = 1'b0;
      3'b010:  in_inc = !in_sign && in_inexact;
      3'b011:  in_inc = in_sign && in_inexact;
      3'b100:  in_inc = in_grs[2];
      default: in_inc = in_grs[2] && (in_grs[1] || in_grs[0] || in_man[0]);
    endcase
  end

  // S1 registers
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_man_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_special_q;
  logic             s1_inc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_man_q     <= '0;
      s1_tag_q     <= '0;
      s1_special_q <= 1'b0;
      s1_inc_q     <= 1'b0;
    end else if (en) begin
      s1_valid_q   <= in_valid;
      s1_sign_q    <= in_sign;
      s1_exp_q     <= in_exp;
      s1_man_q     <= in_man;
      s1_tag_q     <= in_tag;
      s1_special_q <= (in_exp == ExpMax);
      s1_inc_q     <= in_inc;
    end
  end

  // S2 rounding
  logic [MAN_W:0]   man_inc;
  logic             carry;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] res_man;

  always_comb begin
    man_inc = {1'b0, s1_man_q} + {{MAN_W{1'b0}}, s1_inc_q};
    carry   = man_inc[MAN_W];
    res_exp = s1_exp_q;
    res_man = man_inc[MAN_W-1:0];
    if (s1_special_q) begin
      // Inf/NaN pass through untouched whatever the rounding bits say
      res_man = s1_man_q;
    end else if (carry) begin
      res_man = '0;
      // Largest finite exponent rounds up to infinity; exp 0 carries into the normal range
      if (s1_exp_q == ExpMaxM1) res_exp = ExpMax;
      else                      res_exp = s1_exp_q + 1'b1;
    end
  end

  // S2 registers
  logic             out_valid_q;
  logic [D_LEN-1:0] out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      out_data_q  <= {s1_sign_q, res_exp, res_man};
      out_tag_q   <= s1_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef FP_ROUND_FLAGS_EN
  logic       s1_inexact_q;
  logic [2:0] flags_d;
  logic [2:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst)     s1_inexact_q <= 1'b0;
    else if (en) s1_inexact_q <= in_inexact;
  end

  always_comb begin
    flags_d    = 3'b000;
    flags_d[0] = s1_inexact_q && !s1_special_q;
    flags_d[2] = !s1_special_q && carry && (s1_exp_q == ExpMaxM1);
    // Tininess is judged after rounding
    flags_d[1] = flags_d[0] && (res_exp == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)     flags_q <= 3'b000;
    else if (en) flags_q <= flags_d;
  end

  assign out_flags = flags_q;
`else
  assign out_flags = 3'b000;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Testbench for fp_round_pipe: directed vectors checked against a magnitude-arithmetic
// rounding model, a scoreboard compare process on the single-precision instance, and a
// half-precision instance for the parametrised case.
module tb_fp_round_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [2:0]  in_grs, in_mode, out_flags;
  logic [3:0]  in_tag, out_tag;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_in_data, h_out_data;
  logic [2:0]  h_in_grs, h_in_mode, h_out_flags;
  logic [3:0]  h_in_tag, h_out_tag;

  fp_round_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_grs(in_grs), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags)
  );

  fp_round_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_half (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
    .in_grs(h_in_grs), .in_mode(h_in_mode), .in_tag(h_in_tag), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .out_data(h_out_data), .out_tag(h_out_tag),
    .out_flags(h_out_flags)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  flags;
  } res_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef FP_ROUND_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  // Rounding on the magnitude as one integer: a mantissa carry naturally bumps the exponent
  function automatic res_t model(input int ew, input int mw, input logic [31:0] d,
                                 input logic [2:0] grs, input logic [2:0] mode);
    longint unsigned mag, emax;
    logic sign, g, r, s, inx, inc;
    res_t o;
    mag  = {32'b0, d} & ((64'd1 << (ew + mw)) - 64'd1);
    emax = (64'd1 << ew) - 64'd1;
    sign = d[ew + mw];
    g = grs[2]; r = grs[1]; s = grs[0];
    inx = g | r | s;
    if ((mag >> mw) == emax) begin
      o.data  = d;
      o.flags = 3'b000;
      return o;
    end
    case (mode)
      3'd1:    inc = 1'b0;
      3'd2:    inc = !sign && inx;
      3'd3:    inc = sign && inx;
      3'd4:    inc = g;
      default: inc = g && (r || s || mag[0]);
    endcase
    mag     = mag + 64'(inc);
    o.data  = 32'(mag) | (32'(sign) << (ew + mw));
    o.flags = fl({(mag >> mw) == emax, inx && ((mag >> mw) == 64'd0), inx});
    return o;
  endfunction

  // Compare process: retire, stall stability, in_ready, and enqueue on acceptance
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_tag;
  logic [2:0]  prev_flags;

  always @(negedge clk) begin : monitor
    res_t m;
    exp_t e;
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_tag", 32'(out_tag), 32'(prev_tag));
        check("stall_flags", 32'(out_flags), 32'(prev_flags));
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", 32'(out_tag), 32'(e.tag));
          check("out_flags", 32'(out_flags), 32'(e.flags));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        m = model(8, 23, in_data, in_grs, in_mode);
        sb.push_back('{data: m.data, tag: in_tag, flags: m.flags});
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
      prev_flags = out_flags;
    end
  end

  // out_ready driver: high unless the backpressure pattern is enabled
  bit bp_en = 1'b0;
  bit bp_pat[12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    int k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = bp_pat[k % 12];
        k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic drive(input logic [31:0] d, input logic [2:0] g, input logic [2:0] m,
                       input logic [3:0] t);
    bit ok = 1'b0;
    in_data = d; in_grs = g; in_mode = m; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic vec(input string name, input logic [31:0] d, input logic [2:0] g,
                     input logic [2:0] m, input logic [3:0] t, input logic [31:0] ed,
                     input logic [2:0] ef);
    res_t r;
    r = model(8, 23, d, g, m);
    check({name, "_model_data"}, r.data, ed);
    check({name, "_model_flags"}, 32'(r.flags), 32'(fl(ef)));
    drive(d, g, m, t);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !out_valid;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic hvec(input string name, input logic [15:0] d, input logic [2:0] g,
                      input logic [2:0] m, input logic [3:0] t, input logic [15:0] ed,
                      input logic [2:0] ef);
    res_t r;
    r = model(5, 10, {16'b0, d}, g, m);
    check({name, "_model_data"}, r.data, {16'b0, ed});
    check({name, "_model_flags"}, 32'(r.flags), 32'(fl(ef)));
    h_in_data = d; h_in_grs = g; h_in_mode = m; h_in_tag = t; h_in_valid = 1'b1;
    check({name, "_in_ready"}, 32'(h_in_ready), 32'd1);
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
    check({name, "_s1_no_out"}, 32'(h_out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({name, "_valid"}, 32'(h_out_valid), 32'd1);
    check({name, "_data"}, 32'(h_out_data), r.data);
    check({name, "_tag"}, 32'(h_out_tag), 32'(t));
    check({name, "_flags"}, 32'(h_out_flags), 32'(fl(ef)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_grs = '0; in_mode = '0; in_tag = '0;
    h_in_valid = 1'b0; h_in_data = '0; h_in_grs = '0; h_in_mode = '0; h_in_tag = '0;
    h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // RNE ties
    vec("rne_odd", 32'h3F800001, 3'b100, 3'd0, 4'd1, 32'h3F800002, 3'b001);
    vec("rne_even", 32'h3F800000, 3'b100, 3'd0, 4'd2, 32'h3F800000, 3'b001);
    vec("rne_exact", 32'h3F800000, 3'b000, 3'd0, 4'd3, 32'h3F800000, 3'b000);
    // Mode sweep
    vec("rtz", 32'hBF800000, 3'b010, 3'd1, 4'd4, 32'hBF800000, 3'b001);
    vec("rup", 32'hBF800000, 3'b010, 3'd2, 4'd5, 32'hBF800000, 3'b001);
    vec("rdn", 32'hBF800000, 3'b010, 3'd3, 4'd6, 32'hBF800001, 3'b001);
    vec("rmm", 32'hBF800000, 3'b010, 3'd4, 4'd7, 32'hBF800000, 3'b001);
    vec("rne", 32'hBF800000, 3'b010, 3'd0, 4'd8, 32'hBF800000, 3'b001);
    vec("mode5_rne", 32'h3F800001, 3'b100, 3'd5, 4'd13, 32'h3F800002, 3'b001);
    // Boundaries
    vec("ovf", 32'h7F7FFFFF, 3'b110, 3'd0, 4'd9, 32'h7F800000, 3'b101);
    vec("sub_to_norm", 32'h007FFFFF, 3'b100, 3'd2, 4'd10, 32'h00800000, 3'b001);
    vec("tiny", 32'h00000001, 3'b001, 3'd1, 4'd11, 32'h00000001, 3'b011);
    vec("nan", 32'h7FC00000, 3'b111, 3'd0, 4'd12, 32'h7FC00000, 3'b000);
    drain();

    // Backpressure stream
    n0 = n_out;
    bp_en = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      drive(32'h40000000 + 32'(t), 3'(t), 3'(t % 5), 4'(t));
    end
    drain();
    bp_en = 1'b0;
    check("bp_count", 32'(n_out - n0), 32'd6);
    @(posedge clk);
    #1;

    // Reset with two transactions in flight
    drive(32'h3F800001, 3'b100, 3'd0, 4'd7);
    drive(32'h3F800003, 3'b100, 3'd0, 4'd8);
    check("mid_inflight", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mid_no_stale", 32'(out_valid), 32'd0);
    vec("post_rst", 32'h40490FDA, 3'b101, 3'd0, 4'd9, 32'h40490FDB, 3'b001);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("lat_cycle2_tag", 32'(out_tag), 32'd9);
    drain();

    // Half precision
    hvec("half_ovf", 16'h7BFF, 3'b100, 3'd0, 4'd3, 16'h7C00, 3'b101);
    hvec("half_tie", 16'h3C01, 3'b100, 3'd0, 4'd5, 16'h3C02, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
